// File: rtl/vector_processor_pkg.sv
// Shared encodings for the vector logic sequencer: opcodes, SEW/LMUL codes,
// sequencer states, the captured request payload and an element-count helper.
package vector_processor_pkg;

  localparam int unsigned SEW_W     = 3;
  localparam int unsigned LMUL_W    = 2;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned VL_W      = 9;
  localparam int unsigned GRP_W     = 4;  // register counter; holds 0..8

  localparam logic [SEW_W-1:0] SEW_MAX = 3'd5;

  typedef enum logic [2:0] {
    VAND = 3'd0,
    VOR  = 3'd1,
    VXOR = 3'd2,
    VSLL = 3'd3,
    VSRL = 3'd4,
    VSRA = 3'd5
  } alu_opcodes;

  // Element width code: element bits = 8 << code.
  typedef enum logic [SEW_W-1:0] {
    SEW_8   = 3'd0,
    SEW_16  = 3'd1,
    SEW_32  = 3'd2,
    SEW_64  = 3'd3,
    SEW_128 = 3'd4,
    SEW_256 = 3'd5
  } sew_e;

  // Group size code: registers in group = 1 << code.
  typedef enum logic [LMUL_W-1:0] {
    LMUL_1 = 2'd0,
    LMUL_2 = 2'd1,
    LMUL_4 = 2'd2,
    LMUL_8 = 2'd3
  } lmul_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  // Request fields held for the duration of one instruction.
  typedef struct packed {
    alu_opcodes             opcode;
    logic [SEW_W-1:0]       sew;
    logic [LMUL_W-1:0]      lmul;
    logic [REG_IDX_W-1:0]   vd;
    logic [REG_IDX_W-1:0]   vs1;
    logic [REG_IDX_W-1:0]   vs2;
  } vreq_t;

  // Elements held by one register at the given SEW, never less than one.
  function automatic logic [VL_W-1:0] elems_per_reg(input logic [SEW_W-1:0] sew,
                                                    input int unsigned      reg_bytes);
    logic [VL_W-1:0] epr;
    epr = VL_W'(reg_bytes) >> sew;
    if (epr == '0) epr = VL_W'(1);
    return epr;
  endfunction

endpackage

// File: rtl/tail_mask_gen.sv
// Byte-enable generator: enables the low min(remaining, elems_per_reg) << sew
// bytes of a register, leaving the tail bytes disabled.
//   sew       : element width code
//   remaining : elements still to be written
//   mask      : per-byte write enable, VLEN/8 bits
module tail_mask_gen
  import vector_processor_pkg::*;
#(
  parameter int unsigned VLEN = 256
) (
  input  logic [SEW_W-1:0]  sew,
  input  logic [VL_W-1:0]   remaining,
  output logic [VLEN/8-1:0] mask
);

  localparam int unsigned BYTES = VLEN / 8;
  localparam int unsigned CNT_W = 16;

  logic [VL_W-1:0]  epr;
  logic [VL_W-1:0]  active;
  logic [CNT_W-1:0] nbytes;

  always_comb begin
    epr    = elems_per_reg(sew, BYTES);
    active = (remaining < epr) ? remaining : epr;
    nbytes = CNT_W'(active) << sew;
    for (int unsigned i = 0; i < BYTES; i++) begin
      mask[i] = (CNT_W'(i) < nbytes);
    end
  end

endmodule

// File: rtl/vector_logic_sequencer.sv
// Sequencer for vector logic/shift instructions over a register group:
// per register it reads vs1/vs2, runs the external logic unit, and writes vd
// with tail byte enables. Outputs are decoded from registered state.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   req_*, opcode_i .. vl_i    : instruction request handshake and fields
//   rf_rd_*                    : register read port (data one cycle after enable)
//   lu_*                       : combinational logic unit operands/result
//   rf_wr_*                    : register write port with byte enables
//   busy_o, done_o, err_o      : status
module vector_logic_sequencer
  import vector_processor_pkg::*;
#(
  parameter int unsigned VLEN = 256,
  parameter int unsigned NREG = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  alu_opcodes            opcode_i,
  input  logic [SEW_W-1:0]      sew_i,
  input  logic [LMUL_W-1:0]     lmul_i,
  input  logic [REG_IDX_W-1:0]  vd_i,
  input  logic [REG_IDX_W-1:0]  vs1_i,
  input  logic [REG_IDX_W-1:0]  vs2_i,
  input  logic [VL_W-1:0]       vl_i,
  output logic                  rf_rd_en_o,
  output logic [REG_IDX_W-1:0]  rf_rd_addr_a_o,
  output logic [REG_IDX_W-1:0]  rf_rd_addr_b_o,
  input  logic [VLEN-1:0]       rf_rd_data_a_i,
  input  logic [VLEN-1:0]       rf_rd_data_b_i,
  output logic [VLEN-1:0]       lu_a_o,
  output logic [VLEN-1:0]       lu_b_o,
  output logic [SEW_W-1:0]      lu_sew_o,
  output alu_opcodes            lu_opcode_o,
  input  logic [VLEN-1:0]       lu_result_i,
  output logic                  rf_wr_en_o,
  output logic [REG_IDX_W-1:0]  rf_wr_addr_o,
  output logic [VLEN-1:0]       rf_wr_data_o,
  output logic [VLEN/8-1:0]     rf_wr_be_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned BYTES = VLEN / 8;

  seq_state_e          state_q, state_d;
  vreq_t               req_q;
  logic [GRP_W-1:0]    k_q;
  logic [VL_W-1:0]     rem_q;
  logic [VLEN-1:0]     result_q;
  logic                err_q;

  logic                accept_c;
  logic [VL_W-1:0]     epr_c;
  logic [VL_W-1:0]     rem_next_c;
  logic [GRP_W-1:0]    k_next_c;
  logic [GRP_W-1:0]    grp_size_c;
  logic [BYTES-1:0]    be_mask_c;

  // Register index base+k, wrapping around the register file.
  function automatic logic [REG_IDX_W-1:0] wrap_idx(input logic [REG_IDX_W-1:0] base,
                                                    input logic [GRP_W-1:0]     k);
    return REG_IDX_W'((32'(base) + 32'(k)) % NREG);
  endfunction

  assign accept_c   = req_valid_i && (state_q == S_IDLE);
  assign epr_c      = elems_per_reg(req_q.sew, BYTES);
  assign rem_next_c = (rem_q > epr_c) ? (rem_q - epr_c) : '0;
  assign k_next_c   = k_q + GRP_W'(1);
  assign grp_size_c = GRP_W'(1) << req_q.lmul;

  tail_mask_gen #(
    .VLEN(VLEN)
  ) u_tail_mask (
    .sew       (req_q.sew),
    .remaining (rem_q),
    .mask      (be_mask_c)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (sew_i > SEW_MAX || vl_i == '0) state_d = S_DONE;
          else                                state_d = S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      // Stop early once every element is written so no empty-mask write occurs.
      S_WRITE: state_d = (k_next_c < grp_size_c && rem_next_c != '0) ? S_READ : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, counters and logic-unit result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q    <= '0;
      k_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            req_q <= '{opcode: opcode_i, sew: sew_i, lmul: lmul_i,
                       vd: vd_i, vs1: vs1_i, vs2: vs2_i};
            k_q   <= '0;
            rem_q <= vl_i;
            err_q <= (sew_i > SEW_MAX);
          end
        end
        S_EXEC:  result_q <= lu_result_i;
        S_WRITE: begin
          k_q   <= k_next_c;
          rem_q <= rem_next_c;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and registered fields.
  always_comb begin
    req_ready_o    = 1'b0;
    busy_o         = 1'b1;
    rf_rd_en_o     = 1'b0;
    rf_rd_addr_a_o = '0;
    rf_rd_addr_b_o = '0;
    lu_a_o         = '0;
    lu_b_o         = '0;
    lu_sew_o       = '0;
    lu_opcode_o    = VAND;
    rf_wr_en_o     = 1'b0;
    rf_wr_addr_o   = '0;
    rf_wr_data_o   = '0;
    rf_wr_be_o     = '0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_READ: begin
        rf_rd_en_o     = 1'b1;
        rf_rd_addr_a_o = wrap_idx(req_q.vs1, k_q);
        rf_rd_addr_b_o = wrap_idx(req_q.vs2, k_q);
      end
      S_EXEC: begin
        // Port b carries vs2, the shifted/first operand.
        lu_a_o      = rf_rd_data_b_i;
        lu_b_o      = rf_rd_data_a_i;
        lu_sew_o    = req_q.sew;
        lu_opcode_o = req_q.opcode;
      end
      S_WRITE: begin
        rf_wr_en_o   = 1'b1;
        rf_wr_addr_o = wrap_idx(req_q.vd, k_q);
        rf_wr_data_o = result_q;
        rf_wr_be_o   = be_mask_c;
      end
      S_DONE: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vector_logic_sequencer.sv
// Scoreboard bench for vector_logic_sequencer: the driver queues expected
// read/write/done events per instruction, the monitor pops and compares them
// whenever the DUT shows one, including the cycle relative to acceptance.
module tb_vector_logic_sequencer;
  import vector_processor_pkg::*;

  localparam int unsigned VLEN = 256;
  localparam int unsigned NREG = 32;
  localparam int unsigned NB   = VLEN / 8;
  localparam int EV_RD = 0, EV_WR = 1, EV_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  alu_opcodes       opcode_i = VAND;
  logic [2:0]       sew_i = '0;
  logic [1:0]       lmul_i = '0;
  logic [4:0]       vd_i = '0, vs1_i = '0, vs2_i = '0;
  logic [8:0]       vl_i = '0;
  logic             rf_rd_en_o;
  logic [4:0]       rf_rd_addr_a_o, rf_rd_addr_b_o;
  logic [VLEN-1:0]  rf_rd_data_a_i = '0, rf_rd_data_b_i = '0;
  logic [VLEN-1:0]  lu_a_o, lu_b_o, lu_result_i;
  logic [2:0]       lu_sew_o;
  alu_opcodes       lu_opcode_o;
  logic             rf_wr_en_o;
  logic [4:0]       rf_wr_addr_o;
  logic [VLEN-1:0]  rf_wr_data_o;
  logic [NB-1:0]    rf_wr_be_o;
  logic             busy_o, done_o, err_o;

  vector_logic_sequencer #(.VLEN(VLEN), .NREG(NREG)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opcode_i(opcode_i), .sew_i(sew_i), .lmul_i(lmul_i),
    .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vl_i(vl_i),
    .rf_rd_en_o(rf_rd_en_o), .rf_rd_addr_a_o(rf_rd_addr_a_o), .rf_rd_addr_b_o(rf_rd_addr_b_o),
    .rf_rd_data_a_i(rf_rd_data_a_i), .rf_rd_data_b_i(rf_rd_data_b_i),
    .lu_a_o(lu_a_o), .lu_b_o(lu_b_o), .lu_sew_o(lu_sew_o), .lu_opcode_o(lu_opcode_o),
    .lu_result_i(lu_result_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
    .rf_wr_be_o(rf_wr_be_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Static register file contents; read data appears one cycle after enable.
  logic [VLEN-1:0] rf [NREG];
  always @(posedge clk) begin
    if (rf_rd_en_o) begin
      rf_rd_data_a_i <= rf[rf_rd_addr_a_o];
      rf_rd_data_b_i <= rf[rf_rd_addr_b_o];
    end
  end

  // Reference logic unit: a = vs2 (shifted value), b = vs1 (shift amount).
  function automatic logic [VLEN-1:0] lu_ref(input alu_opcodes op, input logic [2:0] sew,
                                             input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic [VLEN-1:0] res, mask, ea, eb, r;
    int w, sh;
    res = '0;
    case (op)
      VAND: res = a & b;
      VOR:  res = a | b;
      VXOR: res = a ^ b;
      default: begin
        w = 8 << sew;
        if (w > int'(VLEN)) w = VLEN;
        mask = (w == int'(VLEN)) ? '1 : ((VLEN'(1) << w) - VLEN'(1));
        for (int e = 0; e < int'(VLEN) / w; e++) begin
          ea = (a >> (e * w)) & mask;
          eb = (b >> (e * w)) & mask;
          sh = int'(eb[7:0]) % w;
          if (op == VSLL)      r = (ea << sh) & mask;
          else if (op == VSRL) r = ea >> sh;
          else r = (ea >> sh) | ((ea[w-1] && sh > 0) ? (mask & ~(mask >> sh)) : '0);
          res = res | (r << (e * w));
        end
      end
    endcase
    return res;
  endfunction

  assign lu_result_i = lu_ref(lu_opcode_o, lu_sew_o, lu_a_o, lu_b_o);

  typedef struct {
    int               kind;
    int               cyc;
    logic [4:0]       a0;
    logic [4:0]       a1;
    logic [VLEN-1:0]  data;
    logic [NB-1:0]    be;
    logic             err;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  ncyc  = 0;
  int  e0    = 0;
  int  n_acc = 0;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk_ev(input int kind, input int cyc);
    ev_t ev;
    ev.kind = kind; ev.cyc = cyc; ev.a0 = '0; ev.a1 = '0;
    ev.data = '0; ev.be = '0; ev.err = 1'b0;
    return ev;
  endfunction

  // Expected event sequence for one instruction.
  task automatic push_op(input alu_opcodes op, input logic [2:0] sew, input logic [1:0] lmul,
                         input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [8:0] vl);
    ev_t ev;
    int rem, epr, k, nb;
    if (sew > 3'd5 || vl == '0) begin
      ev = mk_ev(EV_DONE, 1);
      ev.err = (sew > 3'd5);
      exp_q.push_back(ev);
      return;
    end
    rem = int'(vl);
    epr = 32 >> sew;
    if (epr == 0) epr = 1;
    k = 0;
    do begin
      ev = mk_ev(EV_RD, 3 * k + 1);
      ev.a0 = 5'(int'(vs1) + k);
      ev.a1 = 5'(int'(vs2) + k);
      exp_q.push_back(ev);
      ev = mk_ev(EV_WR, 3 * k + 3);
      ev.a0 = 5'(int'(vd) + k);
      ev.data = lu_ref(op, sew, rf[5'(int'(vs2) + k)], rf[5'(int'(vs1) + k)]);
      nb = ((rem < epr) ? rem : epr) << sew;
      for (int i = 0; i < int'(NB); i++) ev.be[i] = (i < nb);
      exp_q.push_back(ev);
      rem = (rem > epr) ? rem - epr : 0;
      k++;
    end while (k < (1 << lmul) && rem > 0);
    exp_q.push_back(mk_ev(EV_DONE, 3 * k + 1));
  endtask

  // Monitor: acceptance tracking and event comparison on the falling edge.
  always @(negedge clk) begin
    ev_t ev;
    int  rel;
    ncyc++;
    if (!rst_i && req_valid_i && req_ready_o) begin
      e0 = ncyc;
      n_acc++;
    end
    if (err_o) chk("err_with_done", VLEN'(done_o), VLEN'(1));
    if (rf_rd_en_o || rf_wr_en_o || done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", VLEN'({rf_rd_en_o, rf_wr_en_o, done_o}), '0);
      end else begin
        ev  = exp_q.pop_front();
        rel = ncyc - e0;
        if (ev.kind == EV_RD) begin
          chk("rd_en", VLEN'(rf_rd_en_o), VLEN'(1));
          chk("rd_cycle", VLEN'(rel), VLEN'(ev.cyc));
          chk("rd_addr_a", VLEN'(rf_rd_addr_a_o), VLEN'(ev.a0));
          chk("rd_addr_b", VLEN'(rf_rd_addr_b_o), VLEN'(ev.a1));
        end else if (ev.kind == EV_WR) begin
          chk("wr_en", VLEN'(rf_wr_en_o), VLEN'(1));
          chk("wr_cycle", VLEN'(rel), VLEN'(ev.cyc));
          chk("wr_addr", VLEN'(rf_wr_addr_o), VLEN'(ev.a0));
          chk("wr_data", rf_wr_data_o, ev.data);
          chk("wr_be", VLEN'(rf_wr_be_o), VLEN'(ev.be));
        end else begin
          chk("done", VLEN'(done_o), VLEN'(1));
          chk("done_cycle", VLEN'(rel), VLEN'(ev.cyc));
          chk("done_err", VLEN'(err_o), VLEN'(ev.err));
        end
      end
    end
  end

  task automatic issue(input alu_opcodes op, input logic [2:0] sew, input logic [1:0] lmul,
                       input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [8:0] vl, input bit hold);
    int t;
    push_op(op, sew, lmul, vd, vs1, vs2, vl);
    @(posedge clk); #1;
    opcode_i = op; sew_i = sew; lmul_i = lmul;
    vd_i = vd; vs1_i = vs1; vs2_i = vs2; vl_i = vl;
    req_valid_i = 1'b1;
    t = 0;
    while (!req_ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("accept_timeout", VLEN'(req_ready_o), VLEN'(1));
    @(posedge clk); #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      chk("drain_timeout", VLEN'(exp_q.size()), '0);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int acc0, t;
    for (int i = 0; i < int'(NREG); i++)
      for (int w = 0; w < 8; w++)
        rf[i][w*32 +: 32] = (32'(i) * 32'h0100_0193 + 32'(w) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", VLEN'(req_ready_o), VLEN'(1));
    chk("rst_busy", VLEN'(busy_o), '0);
    chk("rst_done", VLEN'(done_o), '0);
    chk("rst_err", VLEN'(err_o), '0);
    chk("rst_rd_en", VLEN'(rf_rd_en_o), '0);
    chk("rst_wr_en", VLEN'(rf_wr_en_o), '0);
    chk("rst_wr_be", VLEN'(rf_wr_be_o), '0);
    chk("rst_lu_a", lu_a_o, '0);
    rst_i = 1'b0;

    // Single register AND: one full write to v3, done in cycle 4.
    issue(VAND, 3'd2, 2'd0, 5'd3, 5'd1, 5'd2, 9'd8, 1'b0);
    chk("busy_during_op", VLEN'(busy_o), VLEN'(1));
    chk("ready_during_op", VLEN'(req_ready_o), '0);
    drain();
    // XOR at 8b over 4 regs, vl=70: three writes, last enables 6 bytes, done cycle 10.
    issue(VXOR, 3'd0, 2'd2, 5'd5, 5'd6, 5'd7, 9'd70, 1'b0);
    drain();
    // Arithmetic shift at 64b with destination wrapping 30,31,0,1.
    issue(VSRA, 3'd3, 2'd2, 5'd30, 5'd8, 5'd9, 9'd16, 1'b0);
    drain();
    // One 256b element per register, sources wrapping past v31.
    issue(VOR, 3'd5, 2'd1, 5'd10, 5'd31, 5'd0, 9'd2, 1'b0);
    drain();
    // Group of 8 cut short after 3 registers, partial last register.
    issue(VSLL, 3'd1, 2'd3, 5'd12, 5'd13, 5'd14, 9'd40, 1'b0);
    drain();
    // Group limit reached before elements run out.
    issue(VSRL, 3'd4, 2'd1, 5'd20, 5'd21, 5'd22, 9'd5, 1'b0);
    drain();
    // vl=0 and illegal SEW finish immediately without register traffic.
    issue(VAND, 3'd2, 2'd0, 5'd3, 5'd1, 5'd2, 9'd0, 1'b0);
    drain();
    issue(VXOR, 3'd7, 2'd2, 5'd3, 5'd1, 5'd2, 9'd8, 1'b0);
    drain();
    issue(VOR, 3'd6, 2'd0, 5'd3, 5'd1, 5'd2, 9'd0, 1'b0);
    drain();

    // Reset during the second EXEC of a 4-register op abandons it.
    issue(VXOR, 3'd3, 2'd2, 5'd16, 5'd17, 5'd18, 9'd16, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_mid_ready", VLEN'(req_ready_o), VLEN'(1));
    chk("rst_mid_busy", VLEN'(busy_o), '0);
    chk("rst_mid_wr_en", VLEN'(rf_wr_en_o), '0);
    chk("rst_mid_done", VLEN'(done_o), '0);
    rst_i = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    // Valid held high: the second acceptance waits until after DONE.
    acc0 = n_acc;
    push_op(VAND, 3'd2, 2'd0, 5'd4, 5'd5, 5'd6, 9'd8);
    issue(VAND, 3'd2, 2'd0, 5'd4, 5'd5, 5'd6, 9'd8, 1'b1);
    t = 0;
    while (n_acc < acc0 + 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    req_valid_i = 1'b0;
    drain();
    chk("held_valid_accepts", VLEN'(n_acc - acc0), VLEN'(2));

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", VLEN'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
